// File: rtl/nfu2_pkg.sv
// ============================================================================
// Module : nfu2_pkg
// Shared op/state encodings and helper functions for the NFU-2 accumulate/pool block.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package nfu2_pkg;

  localparam logic [1:0] OP_SUM = 2'd0;
  localparam logic [1:0] OP_MAX = 2'd1;
  localparam logic [1:0] OP_AVG = 2'd2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACCUM = 3'd1,
    WAIT  = 3'd2,
    FIN   = 3'd3,
    OUT   = 3'd4
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Clamp a wide signed value into the n-bit two's complement range.
  function automatic logic signed [63:0] sat_to_n(input logic signed [63:0] v, input int n);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (n - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/nfu_2_row_tree.sv
// ============================================================================
// Module : nfu_2_row_tree
// Pipelined TN-input adder tree, one register level per tree level, full precision.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module nfu_2_row_tree
  import nfu2_pkg::*;
#(
  parameter int N  = 16,
  parameter int TN = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  input  logic [N*TN-1:0]                 row,
  output logic                            out_valid,
  output logic signed [N+clog2(TN)-1:0]   sum
);

  localparam int L  = clog2(TN);
  localparam int SW = N + L;

  // Heap-indexed nodes: node n has children 2n and 2n+1; indices >= TN are row inputs.
  logic signed [SW-1:0] node_d [1:TN-1];
  logic signed [SW-1:0] node_q [1:TN-1];
  logic [L-1:0]         vld_d;
  logic [L-1:0]         vld_q;

  always_comb begin
    for (int n = 1; n < TN; n++) node_d[n] = '0;
    for (int n = TN / 2; n < TN; n++) begin
      node_d[n] = SW'($signed(row[N*(2*n-TN) +: N])) + SW'($signed(row[N*(2*n+1-TN) +: N]));
    end
    for (int n = 1; n < TN / 2; n++) begin
      node_d[n] = node_q[2*n] + node_q[2*n+1];
    end
    vld_d = (vld_q << 1) | L'(in_valid);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 1; n < TN; n++) node_q[n] <= '0;
      vld_q <= '0;
    end else begin
      for (int n = 1; n < TN; n++) node_q[n] <= node_d[n];
      vld_q <= vld_d;
    end
  end

  assign out_valid = vld_q[L-1];
  assign sum       = node_q[1];

endmodule

`default_nettype wire

// File: rtl/nfu_2_accum_pool.sv
// ============================================================================
// Module : nfu_2_accum_pool
// NFU-2 row-sum trees plus SUM/MAX/AVG tile folding with a saturated TN-lane result.
// Optional build macro: NFU2_RELU_EN clamps negative lane results to zero.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module nfu_2_accum_pool
  import nfu2_pkg::*;
#(
  parameter int N      = 16,
  parameter int TN     = 16,
  parameter int ACC_W  = 32,
  parameter int TILE_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [N*TN*TN-1:0]   i_products,
  input  logic [1:0]           i_op,
  input  logic [TILE_W-1:0]    i_num_tiles,
  input  logic [3:0]           i_avg_shift,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [N*TN-1:0]      o_data,
  output logic                 o_busy
);

  localparam int L  = clog2(TN);
  localparam int SW = N + L;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t              state_q;
  logic                ready_q, valid_q, busy_q;
  logic [N*TN-1:0]     data_q;
  logic [TILE_W-1:0]   cnt_q, num_q;
  logic [1:0]          op_q;
  logic [3:0]          shift_q;

  logic                accept;
  logic [TILE_W-1:0]   num_in, cnt_inc;
  logic                in_first, in_last;
  logic [L-1:0]        first_d, first_q, last_d, last_q;
  logic [TN-1:0]       tree_vld;
  logic                tree_valid;
  logic signed [SW-1:0] tree_sum [TN];

  logic signed [ACC_W-1:0] acc_d [TN];
  logic signed [ACC_W-1:0] acc_q [TN];
  logic                    folded_last_d, folded_last_q;
  logic [N*TN-1:0]         fin_data;

  assign accept   = i_valid & ready_q;
  assign num_in   = (i_num_tiles == '0) ? TILE_W'(1) : i_num_tiles;
  assign cnt_inc  = cnt_q + TILE_W'(1);
  assign in_first = accept & (state_q == IDLE);
  assign in_last  = accept & ((state_q == IDLE) ? (num_in == TILE_W'(1)) : (cnt_inc == num_q));

  for (genvar r = 0; r < TN; r++) begin : g_lane
    nfu_2_row_tree #(.N(N), .TN(TN)) u_tree (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (accept),
      .row       (i_products[N*TN*r +: N*TN]),
      .out_valid (tree_vld[r]),
      .sum       (tree_sum[r])
    );
  end

  assign tree_valid = &tree_vld;

  // First/last markers ride alongside the tree so the fold knows group boundaries.
  always_comb begin
    first_d = (first_q << 1) | L'(in_first);
    last_d  = (last_q << 1) | L'(in_last);
  end

  always_comb begin
    logic signed [ACC_W-1:0] ext;
    logic signed [ACC_W:0]   wide;
    ext  = '0;
    wide = '0;
    for (int r = 0; r < TN; r++) acc_d[r] = acc_q[r];
    folded_last_d = tree_valid & last_q[L-1];
    if (tree_valid) begin
      for (int r = 0; r < TN; r++) begin
        ext = ACC_W'(tree_sum[r]);
        if (first_q[L-1]) begin
          acc_d[r] = ext;
        end else if (op_q == OP_MAX) begin
          acc_d[r] = (ext > acc_q[r]) ? ext : acc_q[r];
        end else begin
          wide = {acc_q[r][ACC_W-1], acc_q[r]} + {ext[ACC_W-1], ext};
          if (wide[ACC_W] != wide[ACC_W-1]) acc_d[r] = wide[ACC_W] ? ACC_MIN : ACC_MAX;
          else                              acc_d[r] = wide[ACC_W-1:0];
        end
      end
    end
  end

  always_comb begin
    logic signed [ACC_W-1:0] v;
    logic signed [63:0]      s;
    v        = '0;
    s        = '0;
    fin_data = '0;
    for (int r = 0; r < TN; r++) begin
      v = (op_q == OP_AVG) ? (acc_q[r] >>> shift_q) : acc_q[r];
      s = sat_to_n(64'(v), N);
`ifdef NFU2_RELU_EN
      if (s < 0) s = '0;
`endif
      fin_data[N*r +: N] = s[N-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < TN; r++) acc_q[r] <= '0;
      folded_last_q <= 1'b0;
      first_q       <= '0;
      last_q        <= '0;
    end else begin
      for (int r = 0; r < TN; r++) acc_q[r] <= acc_d[r];
      folded_last_q <= folded_last_d;
      first_q       <= first_d;
      last_q        <= last_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
      num_q   <= TILE_W'(1);
      op_q    <= OP_SUM;
      shift_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (accept) begin
            op_q    <= i_op;
            num_q   <= num_in;
            shift_q <= i_avg_shift;
            cnt_q   <= TILE_W'(1);
            busy_q  <= 1'b1;
            if (num_in == TILE_W'(1)) begin
              state_q <= WAIT;
              ready_q <= 1'b0;
            end else begin
              state_q <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            cnt_q <= cnt_inc;
            if (cnt_inc == num_q) begin
              state_q <= WAIT;
              ready_q <= 1'b0;
            end
          end
        end
        WAIT: begin
          if (folded_last_q) state_q <= FIN;
        end
        FIN: begin
          data_q  <= fin_data;
          valid_q <= 1'b1;
          state_q <= OUT;
        end
        OUT: begin
          if (i_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready = ready_q;
  assign o_valid = valid_q;
  assign o_busy  = busy_q;
  assign o_data  = data_q;

endmodule

`default_nettype wire
